// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//
// Iterative radix-2 restoring divider producing a WIDTH-bit quotient and a
// WIDTH-bit remainder. One trial subtraction is performed per clock while in
// CALC, so a normal divide spends exactly WIDTH cycles there. Operands enter
// through a valid/ready handshake in IDLE and the result is held in DONE
// until the consumer takes it. Only one operation is in flight at a time.
//
// Optional build macro:
//   DIVIDER_SIGNED_EN - operands are two's complement. Magnitudes are taken
//                       at accept, the unsigned core runs unchanged, and the
//                       quotient/remainder signs are fixed up on the cycle
//                       that enters DONE.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     dividend/divisor valid
//   in_ready     block can accept operands (high only in IDLE)
//   dividend     dividend operand
//   divisor      divisor operand
//   out_valid    result valid (high only in DONE)
//   out_ready    consumer accepts result
//   quotient     quotient result
//   remainder    remainder result
//   div_by_zero  result came from a zero divisor

module seq_restoring_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

`ifdef DIVIDER_SIGNED_EN
    logic negq_q, negq_d;
    logic negr_q, negr_d;

    // The core only ever sees magnitudes; min stays min, which is exactly
    // its magnitude when read as unsigned.
    assign op_a = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign op_b = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
`else
    assign op_a = dividend;
    assign op_b = divisor;
`endif

    // Partial remainder is kept at WIDTH bits: it is always below the
    // divisor, so the top bit of the WIDTH+1-bit remainder is always zero.
    // The shifted value and the trial difference keep the full WIDTH+1 bits
    // so that the borrow shows up in trial[WIDTH].
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr_q};
    assign q_step  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign r_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    // Next-state and datapath updates. A zero divisor skips CALC and loads
    // the all-ones quotient and the raw dividend directly. On the last CALC
    // cycle (counter at 1) the final step is written and DONE is entered;
    // in the signed build the sign fix-up is folded into that same write.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dbz_d = (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
                    negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    negr_d = dividend[WIDTH-1];
`endif
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                    end else begin
                        state_d = CALC;
                        rem_d   = '0;
                        quo_d   = op_a;
                        dsr_d   = op_b;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                quo_d = q_step;
                rem_d = r_step;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
`ifdef DIVIDER_SIGNED_EN
                    if (negq_q) quo_d = ~q_step + WIDTH'(1);
                    if (negr_q) rem_d = ~r_step + WIDTH'(1);
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
//
// Self-checking bench for seq_restoring_divider (WIDTH=8). Expected results
// are pushed to a scoreboard queue when operands are driven and popped when
// the divider presents a result. Follows DIVIDER_SIGNED_EN so the model
// matches the build of the design.

module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock and a cycle counter used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model built from plain integer division.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t m;
`ifdef DIVIDER_SIGNED_EN
        int sa;
        int sb2;
`endif
        if (b == '0) begin
            m.q = '1;
            m.r = a;
            m.z = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            sa  = int'($signed(a));
            sb2 = int'($signed(b));
            m.q = W'(sa / sb2);
            m.r = W'(sa % sb2);
`else
            m.q = a / b;
            m.r = a % b;
`endif
            m.z = 1'b0;
        end
        return m;
    endfunction

    // Present operands until accepted; returns the cycle of the accept edge.
    task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input exp_t e, output int acc_cyc);
        int guard;
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            total++; bad++;
            $display("[TB] FAIL accept_timeout: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; reports the cycle it was first seen.
    task automatic wait_out(output int seen_cyc, output bit ok);
        int guard;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        ok       = (out_valid === 1'b1);
        seen_cyc = cyc;
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        int   acc, seen;
        bit   ok;
        exp_t e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (quotient !== '0) begin bad++; $display("[TB] FAIL rst_quotient: got %0d want 0", quotient); end
        total++; if (remainder !== '0) begin bad++; $display("[TB] FAIL rst_remainder: got %0d want 0", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("[TB] FAIL rst_dbz: got %b want 0", div_by_zero); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort 200/7 partway through CALC with an asynchronous reset.
        push_op(8'd200, 8'd7, model(8'd200, 8'd7), acc);
        sb.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_async_in_ready: got %b want 1", in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_ready: got %b want 1", in_ready); end
        total++; if (quotient !== '0) begin bad++; $display("[TB] FAIL abort_quotient: got %0d want 0", quotient); end
        total++; if (remainder !== '0) begin bad++; $display("[TB] FAIL abort_remainder: got %0d want 0", remainder); end

        push_op(8'd100, 8'd9, model(8'd100, 8'd9), acc);
        wait_out(seen, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL post_reset_timeout: out_valid=%b want 1", out_valid); end
        e = sb.pop_front();
        total++; if (quotient !== e.q) begin bad++; $display("[TB] FAIL post_reset_q: got %0d want %0d", quotient, e.q); end
        total++; if (remainder !== e.r) begin bad++; $display("[TB] FAIL post_reset_r: got %0d want %0d", remainder, e.r); end
        release_out();
    endtask

    task automatic test_unsigned;
        int   acc, seen;
        bit   ok;
        exp_t e;
        push_op(8'd200, 8'd7, model(8'd200, 8'd7), acc);
        wait_out(seen, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL div_timeout: out_valid=%b want 1", out_valid); end
        total++; if (seen - acc + 1 != W + 1) begin bad++; $display("[TB] FAIL div_latency: got %0d want %0d", seen - acc + 1, W + 1); end
        e = sb.pop_front();
        total++; if (quotient !== e.q) begin bad++; $display("[TB] FAIL div_q: got %0d want %0d", quotient, e.q); end
        total++; if (remainder !== e.r) begin bad++; $display("[TB] FAIL div_r: got %0d want %0d", remainder, e.r); end
        total++; if (div_by_zero !== e.z) begin bad++; $display("[TB] FAIL div_dbz: got %b want %b", div_by_zero, e.z); end
        release_out();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL div_drop_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL div_back_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_div_by_zero;
        int   acc, seen;
        bit   ok;
        exp_t e;
        push_op(8'd55, 8'd0, model(8'd55, 8'd0), acc);
        wait_out(seen, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL dbz_timeout: out_valid=%b want 1", out_valid); end
        total++; if (seen - acc + 1 != 1) begin bad++; $display("[TB] FAIL dbz_latency: got %0d want 1", seen - acc + 1); end
        e = sb.pop_front();
        total++; if (quotient !== e.q) begin bad++; $display("[TB] FAIL dbz_q: got %0d want %0d", quotient, e.q); end
        total++; if (remainder !== e.r) begin bad++; $display("[TB] FAIL dbz_r: got %0d want %0d", remainder, e.r); end
        total++; if (div_by_zero !== e.z) begin bad++; $display("[TB] FAIL dbz_flag: got %b want %b", div_by_zero, e.z); end
        release_out();
    endtask

    task automatic test_backpressure;
        int   acc, seen, ghost;
        bit   ok;
        exp_t e;
        push_op(8'd255, 8'd1, model(8'd255, 8'd1), acc);
        wait_out(seen, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL bp_timeout: out_valid=%b want 1", out_valid); end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            total++; if (quotient !== e.q) begin bad++; $display("[TB] FAIL bp_q[%0d]: got %0d want %0d", i, quotient, e.q); end
            total++; if (remainder !== e.r) begin bad++; $display("[TB] FAIL bp_r[%0d]: got %0d want %0d", i, remainder, e.r); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            dividend = 8'd9 + 8'(i);
            divisor  = 8'd3;
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        release_out();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drop_valid: got %b want 0", out_valid); end
        ghost = 0;
        repeat (12) begin
            if (out_valid !== 1'b0) ghost++;
            @(posedge clk); #1;
        end
        total++; if (ghost != 0) begin bad++; $display("[TB] FAIL bp_ghost_result: got %0d valid cycles want 0", ghost); end
    endtask

    task automatic test_boundaries;
        logic [W-1:0] ta[5] = '{8'd5, 8'd77, 8'd0, 8'd255, 8'd64};
        logic [W-1:0] tb[5] = '{8'd9, 8'd1, 8'd13, 8'd255, 8'd8};
        int   acc, seen;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            push_op(ta[i], tb[i], model(ta[i], tb[i]), acc);
            wait_out(seen, ok);
            total++; if (!ok) begin bad++; $display("[TB] FAIL bnd_timeout[%0d]: out_valid=%b want 1", i, out_valid); end
            total++; if (seen - acc + 1 != W + 1) begin bad++; $display("[TB] FAIL bnd_latency[%0d]: got %0d want %0d", i, seen - acc + 1, W + 1); end
            e = sb.pop_front();
            total++; if (quotient !== e.q) begin bad++; $display("[TB] FAIL bnd_q[%0d]: got %0d want %0d", i, quotient, e.q); end
            total++; if (remainder !== e.r) begin bad++; $display("[TB] FAIL bnd_r[%0d]: got %0d want %0d", i, remainder, e.r); end
            total++; if (div_by_zero !== 1'b0) begin bad++; $display("[TB] FAIL bnd_dbz[%0d]: got %b want 0", i, div_by_zero); end
            release_out();
        end
    endtask

    task automatic test_back_to_back;
        int   acc[2];
        int   n_acc, n_res;
        logic rdy;
        exp_t e;
        out_ready = 1'b1;
        sb.push_back(model(8'd13, 8'd5));
        sb.push_back(model(8'd3, 8'd10));
        dividend = 8'd13;
        divisor  = 8'd5;
        in_valid = 1'b1;
        n_acc    = 0;
        n_res    = 0;
        acc      = '{0, 0};
        for (int i = 0; i < 60 && n_res < 2; i++) begin
            rdy = in_ready;
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL b2b_extra_result: got q=%0d want none", quotient);
                end else begin
                    e = sb.pop_front();
                    total++; if (quotient !== e.q) begin bad++; $display("[TB] FAIL b2b_q[%0d]: got %0d want %0d", n_res, quotient, e.q); end
                    total++; if (remainder !== e.r) begin bad++; $display("[TB] FAIL b2b_r[%0d]: got %0d want %0d", n_res, remainder, e.r); end
                end
                n_res++;
            end
            @(posedge clk); #1;
            if (rdy === 1'b1 && in_valid && n_acc < 2) begin
                acc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    dividend = 8'd3;
                    divisor  = 8'd10;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (n_res != 2) begin bad++; $display("[TB] FAIL b2b_results: got %0d want 2", n_res); end
        total++; if (acc[1] - acc[0] != W + 2) begin bad++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", acc[1] - acc[0], W + 2); end
        @(posedge clk); #1;
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed;
        logic [W-1:0] sa[3] = '{8'hF9, 8'h07, 8'h80};
        logic [W-1:0] sd[3] = '{8'h02, 8'hFE, 8'hFF};
        logic [W-1:0] eq[3] = '{8'hFD, 8'hFD, 8'h80};
        logic [W-1:0] er[3] = '{8'hFF, 8'h01, 8'h00};
        int   acc, seen;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            push_op(sa[i], sd[i], exp_t'{q: eq[i], r: er[i], z: 1'b0}, acc);
            wait_out(seen, ok);
            total++; if (!ok) begin bad++; $display("[TB] FAIL sgn_timeout[%0d]: out_valid=%b want 1", i, out_valid); end
            total++; if (seen - acc + 1 != W + 1) begin bad++; $display("[TB] FAIL sgn_latency[%0d]: got %0d want %0d", i, seen - acc + 1, W + 1); end
            e = sb.pop_front();
            total++; if (quotient !== e.q) begin bad++; $display("[TB] FAIL sgn_q[%0d]: got %0h want %0h", i, quotient, e.q); end
            total++; if (remainder !== e.r) begin bad++; $display("[TB] FAIL sgn_r[%0d]: got %0h want %0h", i, remainder, e.r); end
            release_out();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_div_by_zero();
        test_backpressure();
        test_boundaries();
        test_back_to_back();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
